pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Sequencing controller for the 5-stage pipeline latches (F/D, D/X, X/M, M/W) and the PC register. Every cycle it produces the latch enable and clear pulses. It detects load-use hazards and taken-branch flushes, and runs the multi-cycle mult/div handshake, freezing the front end until the unit answers or times out. It also keeps a stall-cycle counter for debug readout.

## Interface
- MD_TIMEOUT, 40: max cycles waited for md_rdy before abort (≥2, ≤255)
- INIT_CYCLES, 2: cycles all latches held cleared after reset release (≥1, ≤15)
- clock  in  1  system clock, rising edge
- res  in  1  reset, asynchronous assert, active-low
- fd_instr  in  32  instruction at F/D latch output (decode stage)
- dx_instr  in  32  instruction at D/X latch output (execute stage)
- br_taken  in  1  execute-stage branch/jump redirect this cycle
- md_rdy  in  1  mult/div result valid (one-cycle pulse)
- pc_en, fd_en, dx_en, xm_en, mw_en  out  1 each  register/latch load enables
- fd_clr, dx_clr, xm_clr, mw_clr  out  1 each  latch loads all-zero (nop) on next edge
- md_start  out  1  one-cycle start pulse to mult/div
- md_err  out  1  sticky timeout flag
- stall_cnt  out  32  count of cycles with pc_en=0 after INIT

## Operation
- Fields: opcode[31:27], rd[26:22], rs[21:17], rt[16:12], aluop[6:2]. Register 0 never causes a hazard.
- Decode sources:
  - rs always.
  - rt if opcode=00000.
  - rd if opcode ∈ {00111 sw, 00010 bne, 00110 blt}.
- Load-use: dx opcode=01000 (lw), dx.rd≠0, and dx.rd equals any decode source.
- Multdiv: dx opcode=00000 with aluop ∈ {00110, 00111}.
- States: INIT, RUN, MD_BUSY.
- INIT (entered on reset):
  - All enables 0, all clr 1.
  - 4-bit counter runs to INIT_CYCLES−1, then RUN.
- RUN, in priority order:
  1. br_taken: all enables 1, fd_clr=dx_clr=1. A simultaneous load-use hazard is ignored.
  2. Multdiv in X: md_start=1; pc_en=fd_en=dx_en=0; xm_clr=1; xm_en=1; mw_en=1; next MD_BUSY with 8-bit timer cleared.
  3. Load-use: pc_en=fd_en=0; dx_clr=1; dx_en, xm_en, mw_en=1.
  4. Otherwise all enables 1, all clr 0.
- MD_BUSY:
  - pc_en=fd_en=dx_en=0; xm_clr=1; mw_en=1; timer increments.
  - md_rdy: all enables 1, xm_clr=0 (result captured into X/M); next RUN. A load-use check against the new decode instruction resumes from RUN on the following cycle.
  - Timer reaches MD_TIMEOUT−1 with no md_rdy: md_err←1; all enables 1, xm_clr=1 (result dropped); next RUN.
- md_start is asserted only on the RUN→MD_BUSY transition, so each multdiv instruction starts the unit exactly once.
- md_rdy outside MD_BUSY is ignored.
- stall_cnt increments (wrapping at 2^32) on every clock where pc_en=0 and state≠INIT.
- clr has priority over en inside the latch wrapper: clr=1 loads zero regardless of en.

## Timing
- State, counters, md_err, and stall_cnt are registered. All enable/clr/md_start outputs are combinational from state and current inputs (Mealy), valid before the next edge.
- Reset asserted (res=0), immediately:
  - state=INIT; enables 0; clr 1; md_start 0; md_err 0; stall_cnt 0; timers 0.
- Reset released mid-multdiv: the in-flight operation is abandoned. The mult/div unit is reset by the same res.
- Latency:
  - Load-use stall costs 1 cycle.
  - Branch flush costs 2 bubbles.
  - Multdiv occupies X for (cycles from md_start to md_rdy)+1.
  - Timeout abort occurs exactly MD_TIMEOUT cycles after md_start.

## Structure
- Package pipe_ctrl_pkg holds:
  - opcode constants (00000, 01000, 00111, 00010, 00110);
  - aluop constants 00110/00111;
  - field bit positions;
  - the state encoding (INIT=2'b00, RUN=2'b01, MD_BUSY=2'b10; 2'b11 recovers to INIT).
- Sub-module hazard_detect (combinational) takes fd_instr and dx_instr and returns load_use and is_multdiv.
- The FSM, timers, and stall counter live in pipe_ctrl.

## Test plan
- Reset held 3 cycles, released → all clr=1 for exactly 2 cycles, then all enables 1 with nop instructions; stall_cnt=0.
- dx=lw r5, fd=add r6,r5,r2 → 1 cycle pc_en=fd_en=0, dx_clr=1; stall_cnt=1; next cycle no stall.
- Same lw hazard with br_taken=1 in the same cycle → no stall; fd_clr=dx_clr=1; pc_en=1.
- dx=mul (aluop 00110), md_rdy returned 5 cycles after md_start → md_start high 1 cycle; front end frozen 5 cycles; xm_en=1 with xm_clr=0 on the md_rdy cycle; stall_cnt=5.
- MD_TIMEOUT=4, md_rdy never asserted → md_err rises 4 cycles after md_start and stays high; pipeline resumes; X/M receives a nop; second mul gets a fresh md_start.
- res dropped during MD_BUSY → next cycle state INIT; md_err=0; stall_cnt=0; late md_rdy is ignored.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline sequencing controller: instruction
// field positions, the opcode/aluop values the controller cares about and
// the FSM state encoding.
// Ports: none (package).
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

  // Instruction field bit positions
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RD_MSB  = 26;
  localparam int RD_LSB  = 22;
  localparam int RS_MSB  = 21;
  localparam int RS_LSB  = 17;
  localparam int RT_MSB  = 16;
  localparam int RT_LSB  = 12;
  localparam int ALU_MSB = 6;
  localparam int ALU_LSB = 2;

  // Opcodes
  localparam logic [4:0] OPC_ALU = 5'b00000;
  localparam logic [4:0] OPC_LW  = 5'b01000;
  localparam logic [4:0] OPC_SW  = 5'b00111;
  localparam logic [4:0] OPC_BNE = 5'b00010;
  localparam logic [4:0] OPC_BLT = 5'b00110;

  // ALU sub-operations routed to the multi-cycle mult/div unit
  localparam logic [4:0] ALUOP_MUL = 5'b00110;
  localparam logic [4:0] ALUOP_DIV = 5'b00111;

  // Controller state; the unused code falls back to INIT
  typedef enum logic [1:0] {
    ST_INIT    = 2'b00,
    ST_RUN     = 2'b01,
    ST_MD_BUSY = 2'b10,
    ST_BAD     = 2'b11
  } state_t;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
// Combinational decode of the instructions sitting in decode (F/D output)
// and execute (D/X output).
// Ports:
//   fd_instr   in  32  instruction in decode
//   dx_instr   in  32  instruction in execute
//   load_use   out 1   execute lw writes a register decode reads
//   is_multdiv out 1   execute instruction needs the mult/div unit
// ---------------------------------------------------------------------------
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [31:0] fd_instr,
  input  logic [31:0] dx_instr,
  output logic        load_use,
  output logic        is_multdiv
);

  logic [4:0] fd_op;
  logic [4:0] fd_rd;
  logic [4:0] fd_rs;
  logic [4:0] fd_rt;
  logic [4:0] dx_op;
  logic [4:0] dx_rd;
  logic [4:0] dx_alu;
  logic       rt_is_src;
  logic       rd_is_src;
  logic       unused_bits;

  assign fd_op  = fd_instr[OPC_MSB:OPC_LSB];
  assign fd_rd  = fd_instr[RD_MSB:RD_LSB];
  assign fd_rs  = fd_instr[RS_MSB:RS_LSB];
  assign fd_rt  = fd_instr[RT_MSB:RT_LSB];
  assign dx_op  = dx_instr[OPC_MSB:OPC_LSB];
  assign dx_rd  = dx_instr[RD_MSB:RD_LSB];
  assign dx_alu = dx_instr[ALU_MSB:ALU_LSB];

  // Only R-type reads rt; stores and compare-branches read the rd field.
  assign rt_is_src = (fd_op == OPC_ALU);
  assign rd_is_src = (fd_op == OPC_SW) || (fd_op == OPC_BNE) || (fd_op == OPC_BLT);

  // r0 is hard-wired, so a lw targeting it can never feed a consumer.
  assign load_use = (dx_op == OPC_LW) && (dx_rd != 5'd0) &&
                    ((dx_rd == fd_rs) ||
                     (rt_is_src && (dx_rd == fd_rt)) ||
                     (rd_is_src && (dx_rd == fd_rd)));

  assign is_multdiv = (dx_op == OPC_ALU) &&
                      ((dx_alu == ALUOP_MUL) || (dx_alu == ALUOP_DIV));

  // Fields the controller never looks at
  assign unused_bits = ^{fd_instr[11:0], dx_instr[21:7], dx_instr[1:0]};

endmodule

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
// Sequencing controller for the PC register and the F/D, D/X, X/M, M/W
// latches. Handles load-use stalls, taken-branch flushes and the mult/div
// start/wait/timeout handshake, and counts stalled cycles for debug.
// Parameters:
//   MD_TIMEOUT  cycles waited for md_rdy before abort (2..255)
//   INIT_CYCLES cycles latches are held cleared after reset (1..15)
// Ports:
//   clock                          in  1   rising-edge clock
//   res                            in  1   async active-low reset
//   fd_instr, dx_instr             in  32  decode / execute instructions
//   br_taken                       in  1   execute-stage redirect
//   md_rdy                         in  1   mult/div result valid pulse
//   pc_en, fd_en, dx_en, xm_en, mw_en out 1 load enables
//   fd_clr, dx_clr, xm_clr, mw_clr out 1   load nop on next edge
//   md_start                       out 1   mult/div start pulse
//   md_err                         out 1   sticky mult/div timeout
//   stall_cnt                      out 32  cycles with pc_en=0 after INIT
// ---------------------------------------------------------------------------
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT  = 40,
  parameter int INIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        res,
  input  logic [31:0] fd_instr,
  input  logic [31:0] dx_instr,
  input  logic        br_taken,
  input  logic        md_rdy,
  output logic        pc_en,
  output logic        fd_en,
  output logic        dx_en,
  output logic        xm_en,
  output logic        mw_en,
  output logic        fd_clr,
  output logic        dx_clr,
  output logic        xm_clr,
  output logic        mw_clr,
  output logic        md_start,
  output logic        md_err,
  output logic [31:0] stall_cnt
);

  localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);
  localparam logic [7:0] MD_LAST   = 8'(MD_TIMEOUT - 1);

  state_t      state_reg;
  state_t      state_next;
  logic [3:0]  init_cnt_reg;
  logic [7:0]  md_timer_reg;
  logic        md_err_reg;
  logic [31:0] stall_cnt_reg;

  logic load_use;
  logic is_multdiv;
  logic init_done;
  logic md_expired;

  hazard_detect u_hazard (
    .fd_instr  (fd_instr),
    .dx_instr  (dx_instr),
    .load_use  (load_use),
    .is_multdiv(is_multdiv)
  );

  assign init_done  = (init_cnt_reg == INIT_LAST);
  assign md_expired = (md_timer_reg == MD_LAST);

  // State register
  always_ff @(posedge clock or negedge res) begin
    if (!res) begin
      state_reg <= ST_INIT;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = ST_INIT;
    case (state_reg)
      ST_INIT:    state_next = init_done ? ST_RUN : ST_INIT;
      ST_RUN: begin
        // A redirect squashes whatever sits in X, multdiv included.
        if (!br_taken && is_multdiv) state_next = ST_MD_BUSY;
        else                         state_next = ST_RUN;
      end
      ST_MD_BUSY: state_next = (md_rdy || md_expired) ? ST_RUN : ST_MD_BUSY;
      default:    state_next = ST_INIT;
    endcase
  end

  // Output logic (Mealy on br_taken, hazards and md_rdy)
  always_comb begin
    pc_en    = 1'b0;
    fd_en    = 1'b0;
    dx_en    = 1'b0;
    xm_en    = 1'b0;
    mw_en    = 1'b0;
    fd_clr   = 1'b0;
    dx_clr   = 1'b0;
    xm_clr   = 1'b0;
    mw_clr   = 1'b0;
    md_start = 1'b0;
    case (state_reg)
      ST_RUN: begin
        if (br_taken) begin
          {pc_en, fd_en, dx_en, xm_en, mw_en} = 5'b11111;
          fd_clr = 1'b1;
          dx_clr = 1'b1;
        end else if (is_multdiv) begin
          // Freeze the front end; X/M takes bubbles until the result lands.
          md_start = 1'b1;
          xm_clr   = 1'b1;
          xm_en    = 1'b1;
          mw_en    = 1'b1;
        end else if (load_use) begin
          dx_clr = 1'b1;
          dx_en  = 1'b1;
          xm_en  = 1'b1;
          mw_en  = 1'b1;
        end else begin
          {pc_en, fd_en, dx_en, xm_en, mw_en} = 5'b11111;
        end
      end
      ST_MD_BUSY: begin
        if (md_rdy) begin
          {pc_en, fd_en, dx_en, xm_en, mw_en} = 5'b11111;
        end else if (md_expired) begin
          // Abort: let the pipe advance but drop the missing result.
          {pc_en, fd_en, dx_en, xm_en, mw_en} = 5'b11111;
          xm_clr = 1'b1;
        end else begin
          xm_en  = 1'b1;
          xm_clr = 1'b1;
          mw_en  = 1'b1;
        end
      end
      default: begin
        // INIT and the unused encoding keep every latch cleared.
        {fd_clr, dx_clr, xm_clr, mw_clr} = 4'b1111;
      end
    endcase
  end

  // Timers, sticky error and stall counter
  always_ff @(posedge clock or negedge res) begin
    if (!res) begin
      init_cnt_reg  <= 4'd0;
      md_timer_reg  <= 8'd0;
      md_err_reg    <= 1'b0;
      stall_cnt_reg <= 32'd0;
    end else begin
      if (state_reg == ST_INIT && !init_done) init_cnt_reg <= init_cnt_reg + 4'd1;
      else                                    init_cnt_reg <= 4'd0;

      // Cleared on every cycle outside MD_BUSY so each start sees a fresh timer.
      if (state_reg == ST_MD_BUSY && state_next == ST_MD_BUSY)
        md_timer_reg <= md_timer_reg + 8'd1;
      else
        md_timer_reg <= 8'd0;

      if (state_reg == ST_MD_BUSY && !md_rdy && md_expired) md_err_reg <= 1'b1;

      if ((state_reg == ST_RUN || state_reg == ST_MD_BUSY) && !pc_en)
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign md_err    = md_err_reg;
  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl
// Directed bench for pipe_ctrl. Two instances share stimulus: dut uses the
// default parameters, dut_t uses MD_TIMEOUT=4 with md_rdy tied low so the
// abort path can be exercised quickly. Control outputs are packed as
// {pc,fd,dx,xm,mw enables, fd,dx,xm,mw clears, md_start}.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;

  // Expected control vectors
  localparam logic [9:0] C_INIT = 10'b00000_1111_0;
  localparam logic [9:0] C_RUN  = 10'b11111_0000_0;
  localparam logic [9:0] C_LU   = 10'b00111_0100_0;
  localparam logic [9:0] C_BR   = 10'b11111_1100_0;
  localparam logic [9:0] C_MDS  = 10'b00011_0010_1;
  localparam logic [9:0] C_MDW  = 10'b00011_0010_0;
  localparam logic [9:0] C_MDT  = 10'b11111_0010_0;

  localparam logic [4:0] ALU = 5'b00000;
  localparam logic [4:0] LW  = 5'b01000;
  localparam logic [4:0] SW  = 5'b00111;
  localparam logic [4:0] BNE = 5'b00010;
  localparam logic [4:0] BLT = 5'b00110;

  logic        clock = 1'b0;
  logic        res;
  logic [31:0] fd_instr;
  logic [31:0] dx_instr;
  logic        br_taken;
  logic        md_rdy;

  logic pc_en, fd_en, dx_en, xm_en, mw_en, fd_clr, dx_clr, xm_clr, mw_clr, md_start, md_err;
  logic [31:0] stall_cnt;
  logic pc_en_t, fd_en_t, dx_en_t, xm_en_t, mw_en_t, fd_clr_t, dx_clr_t, xm_clr_t, mw_clr_t;
  logic md_start_t, md_err_t;
  logic [31:0] stall_cnt_t;

  logic [9:0] ctrl;
  logic [9:0] ctrl_t;

  int checks = 0;
  int failures = 0;
  int exp_stall = 0;

  always #5 clock = ~clock;

  assign ctrl   = {pc_en, fd_en, dx_en, xm_en, mw_en, fd_clr, dx_clr, xm_clr, mw_clr, md_start};
  assign ctrl_t = {pc_en_t, fd_en_t, dx_en_t, xm_en_t, mw_en_t,
                   fd_clr_t, dx_clr_t, xm_clr_t, mw_clr_t, md_start_t};

  pipe_ctrl dut (
    .clock(clock), .res(res), .fd_instr(fd_instr), .dx_instr(dx_instr),
    .br_taken(br_taken), .md_rdy(md_rdy),
    .pc_en(pc_en), .fd_en(fd_en), .dx_en(dx_en), .xm_en(xm_en), .mw_en(mw_en),
    .fd_clr(fd_clr), .dx_clr(dx_clr), .xm_clr(xm_clr), .mw_clr(mw_clr),
    .md_start(md_start), .md_err(md_err), .stall_cnt(stall_cnt)
  );

  pipe_ctrl #(.MD_TIMEOUT(4), .INIT_CYCLES(2)) dut_t (
    .clock(clock), .res(res), .fd_instr(fd_instr), .dx_instr(dx_instr),
    .br_taken(br_taken), .md_rdy(1'b0),
    .pc_en(pc_en_t), .fd_en(fd_en_t), .dx_en(dx_en_t), .xm_en(xm_en_t), .mw_en(mw_en_t),
    .fd_clr(fd_clr_t), .dx_clr(dx_clr_t), .xm_clr(xm_clr_t), .mw_clr(mw_clr_t),
    .md_start(md_start_t), .md_err(md_err_t), .stall_cnt(stall_cnt_t)
  );

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] alu);
    return {op, rd, rs, rt, 5'b00000, alu, 2'b00};
  endfunction

  // Inputs change just after the rising edge; outputs are sampled at the falling edge.
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    fd_instr = 32'd0;
    dx_instr = 32'd0;
    br_taken = 1'b0;
    md_rdy   = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    res = 1'b0;
    #1;
    checks++;
    if (ctrl !== C_INIT) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl, C_INIT);
    end
    checks++;
    if (md_err !== 1'b0 || stall_cnt !== 32'd0) begin
      failures++; $display("FAIL reset_regs got md_err=%b stall=%0d exp 0/0", md_err, stall_cnt);
    end
    repeat (3) @(posedge clock);
    #1;
    res = 1'b1;
    @(negedge clock);
    checks++;
    if (ctrl !== C_INIT) begin
      failures++; $display("FAIL init_cycle0 got=%b exp=%b", ctrl, C_INIT);
    end
    $display("reset: init cycle 0 ctrl=%b", ctrl);
    next_cycle();
    @(negedge clock);
    checks++;
    if (ctrl !== C_INIT) begin
      failures++; $display("FAIL init_cycle1 got=%b exp=%b", ctrl, C_INIT);
    end
    $display("reset: init cycle 1 ctrl=%b", ctrl);
    next_cycle();
    @(negedge clock);
    checks++;
    if (ctrl !== C_RUN) begin
      failures++; $display("FAIL run_after_init got=%b exp=%b", ctrl, C_RUN);
    end
    checks++;
    if (stall_cnt !== 32'd0) begin
      failures++; $display("FAIL init_stall got=%0d exp=0", stall_cnt);
    end
    $display("reset: run ctrl=%b stall_cnt=%0d", ctrl, stall_cnt);
    exp_stall = 0;
  endtask

  task automatic test_load_use();
    logic [31:0] dxv;
    logic [31:0] fdv;
    logic [9:0]  expv;
    next_cycle();
    dx_instr = mk(LW, 5'd5, 5'd1, 5'd0, 5'd0);
    fd_instr = mk(ALU, 5'd6, 5'd5, 5'd2, 5'd0);
    @(negedge clock);
    checks++;
    if (ctrl !== C_LU) begin
      failures++; $display("FAIL lu_rs got=%b exp=%b", ctrl, C_LU);
    end
    $display("load_use: lw r5 / add r6,r5,r2 ctrl=%b", ctrl);
    exp_stall++;
    next_cycle();
    dx_instr = 32'd0;
    @(negedge clock);
    checks++;
    if (stall_cnt !== 32'(exp_stall)) begin
      failures++; $display("FAIL lu_stall_cnt got=%0d exp=%0d", stall_cnt, exp_stall);
    end
    checks++;
    if (ctrl !== C_RUN) begin
      failures++; $display("FAIL lu_resume got=%b exp=%b", ctrl, C_RUN);
    end
    $display("load_use: bubble cycle ctrl=%b stall_cnt=%0d", ctrl, stall_cnt);
    for (int i = 0; i < 8; i++) begin
      dxv = mk(LW, 5'd5, 5'd1, 5'd0, 5'd0);
      fdv = 32'd0;
      expv = C_LU;
      case (i)
        0: fdv = mk(ALU, 5'd6, 5'd2, 5'd5, 5'd0);            // rt source
        1: fdv = mk(SW, 5'd5, 5'd1, 5'd2, 5'd0);             // sw reads rd
        2: fdv = mk(BNE, 5'd5, 5'd3, 5'd4, 5'd0);            // bne reads rd
        3: fdv = mk(BLT, 5'd5, 5'd3, 5'd4, 5'd0);            // blt reads rd
        4: begin                                             // lw r0
          dxv = mk(LW, 5'd0, 5'd1, 5'd0, 5'd0);
          fdv = mk(ALU, 5'd6, 5'd0, 5'd0, 5'd0);
          expv = C_RUN;
        end
        5: begin                                             // lw consumer: rd/rt not read
          fdv = mk(LW, 5'd5, 5'd1, 5'd5, 5'd0);
          expv = C_RUN;
        end
        6: begin                                             // producer is not a load
          dxv = mk(ALU, 5'd5, 5'd1, 5'd2, 5'd0);
          fdv = mk(ALU, 5'd6, 5'd5, 5'd2, 5'd0);
          expv = C_RUN;
        end
        default: begin                                       // I-type: rd/rt not read
          fdv = mk(5'b00001, 5'd5, 5'd3, 5'd5, 5'd0);
          expv = C_RUN;
        end
      endcase
      next_cycle();
      dx_instr = dxv;
      fd_instr = fdv;
      @(negedge clock);
      checks++;
      if (ctrl !== expv) begin
        failures++; $display("FAIL lu_case%0d got=%b exp=%b", i, ctrl, expv);
      end
      $display("load_use: case %0d dx=%h fd=%h ctrl=%b", i, dxv, fdv, ctrl);
      if (expv == C_LU) exp_stall++;
    end
    next_cycle();
    idle_inputs();
    checks++;
    if (stall_cnt !== 32'(exp_stall)) begin
      failures++; $display("FAIL lu_table_stall got=%0d exp=%0d", stall_cnt, exp_stall);
    end
  endtask

  task automatic test_branch_flush();
    next_cycle();
    dx_instr = mk(LW, 5'd5, 5'd1, 5'd0, 5'd0);
    fd_instr = mk(ALU, 5'd6, 5'd5, 5'd2, 5'd0);
    br_taken = 1'b1;
    @(negedge clock);
    checks++;
    if (ctrl !== C_BR) begin
      failures++; $display("FAIL br_over_lu got=%b exp=%b", ctrl, C_BR);
    end
    $display("branch: taken with lw hazard ctrl=%b", ctrl);
    next_cycle();
    idle_inputs();
    @(negedge clock);
    checks++;
    if (stall_cnt !== 32'(exp_stall)) begin
      failures++; $display("FAIL br_stall got=%0d exp=%0d", stall_cnt, exp_stall);
    end
    checks++;
    if (ctrl !== C_RUN) begin
      failures++; $display("FAIL br_after got=%b exp=%b", ctrl, C_RUN);
    end
    $display("branch: after flush ctrl=%b stall_cnt=%0d", ctrl, stall_cnt);
  endtask

  task automatic test_multdiv();
    next_cycle();
    dx_instr = mk(ALU, 5'd3, 5'd1, 5'd2, 5'b00110);
    fd_instr = mk(ALU, 5'd4, 5'd3, 5'd1, 5'd0);
    @(negedge clock);
    checks++;
    if (ctrl !== C_MDS) begin
      failures++; $display("FAIL md_start got=%b exp=%b", ctrl, C_MDS);
    end
    $display("multdiv: mul start ctrl=%b", ctrl);
    for (int i = 1; i <= 4; i++) begin
      next_cycle();
      @(negedge clock);
      checks++;
      if (ctrl !== C_MDW) begin
        failures++; $display("FAIL md_wait%0d got=%b exp=%b", i, ctrl, C_MDW);
      end
      $display("multdiv: wait %0d ctrl=%b", i, ctrl);
    end
    next_cycle();
    md_rdy = 1'b1;
    @(negedge clock);
    checks++;
    if (ctrl !== C_RUN) begin
      failures++; $display("FAIL md_rdy_capture got=%b exp=%b", ctrl, C_RUN);
    end
    $display("multdiv: md_rdy ctrl=%b", ctrl);
    exp_stall += 5;
    next_cycle();
    md_rdy = 1'b0;
    dx_instr = 32'd0;
    @(negedge clock);
    checks++;
    if (stall_cnt !== 32'(exp_stall)) begin
      failures++; $display("FAIL md_stall_cnt got=%0d exp=%0d", stall_cnt, exp_stall);
    end
    checks++;
    if (ctrl !== C_RUN) begin
      failures++; $display("FAIL md_resume got=%b exp=%b", ctrl, C_RUN);
    end
    $display("multdiv: resumed ctrl=%b stall_cnt=%0d", ctrl, stall_cnt);
    // Stray md_rdy in RUN must change nothing
    next_cycle();
    md_rdy = 1'b1;
    @(negedge clock);
    checks++;
    if (ctrl !== C_RUN) begin
      failures++; $display("FAIL stray_rdy got=%b exp=%b", ctrl, C_RUN);
    end
    // div answering on the first busy cycle
    next_cycle();
    md_rdy = 1'b0;
    dx_instr = mk(ALU, 5'd7, 5'd1, 5'd2, 5'b00111);
    @(negedge clock);
    checks++;
    if (ctrl !== C_MDS) begin
      failures++; $display("FAIL div_start got=%b exp=%b", ctrl, C_MDS);
    end
    next_cycle();
    md_rdy = 1'b1;
    @(negedge clock);
    checks++;
    if (ctrl !== C_RUN) begin
      failures++; $display("FAIL div_rdy got=%b exp=%b", ctrl, C_RUN);
    end
    $display("multdiv: div one-cycle answer ctrl=%b", ctrl);
    exp_stall += 1;
    next_cycle();
    idle_inputs();
    checks++;
    if (stall_cnt !== 32'(exp_stall)) begin
      failures++; $display("FAIL div_stall_cnt got=%0d exp=%0d", stall_cnt, exp_stall);
    end
  endtask

  task automatic test_timeout();
    idle_inputs();
    res = 1'b0;
    @(posedge clock);
    #1;
    res = 1'b1;
    next_cycle();
    next_cycle();
    dx_instr = mk(ALU, 5'd3, 5'd1, 5'd2, 5'b00110);
    @(negedge clock);
    checks++;
    if (ctrl_t !== C_MDS) begin
      failures++; $display("FAIL to_start got=%b exp=%b", ctrl_t, C_MDS);
    end
    for (int i = 1; i <= 3; i++) begin
      next_cycle();
      @(negedge clock);
      checks++;
      if (ctrl_t !== C_MDW || md_err_t !== 1'b0) begin
        failures++; $display("FAIL to_wait%0d got=%b err=%b exp=%b err=0", i, ctrl_t, md_err_t, C_MDW);
      end
    end
    next_cycle();
    @(negedge clock);
    checks++;
    if (ctrl_t !== C_MDT || md_err_t !== 1'b0) begin
      failures++; $display("FAIL to_abort got=%b err=%b exp=%b err=0", ctrl_t, md_err_t, C_MDT);
    end
    $display("timeout: abort cycle ctrl=%b md_err=%b", ctrl_t, md_err_t);
    next_cycle();
    dx_instr = mk(ALU, 5'd9, 5'd1, 5'd2, 5'b00110);
    @(negedge clock);
    checks++;
    if (md_err_t !== 1'b1) begin
      failures++; $display("FAIL to_err_set got=%b exp=1", md_err_t);
    end
    checks++;
    if (stall_cnt_t !== 32'd4) begin
      failures++; $display("FAIL to_stall got=%0d exp=4", stall_cnt_t);
    end
    checks++;
    if (ctrl_t !== C_MDS) begin
      failures++; $display("FAIL to_second_start got=%b exp=%b", ctrl_t, C_MDS);
    end
    $display("timeout: second mul ctrl=%b md_err=%b stall_cnt=%0d", ctrl_t, md_err_t, stall_cnt_t);
    next_cycle();
    @(negedge clock);
    checks++;
    if (ctrl_t !== C_MDW || md_err_t !== 1'b1) begin
      failures++; $display("FAIL to_err_sticky got=%b err=%b exp=%b err=1", ctrl_t, md_err_t, C_MDW);
    end
  endtask

  task automatic test_reset_mid_md();
    // Main dut has been waiting on its mul since the timeout scenario began.
    @(posedge clock);
    #2;
    checks++;
    if (ctrl !== C_MDW) begin
      failures++; $display("FAIL pre_reset_busy got=%b exp=%b", ctrl, C_MDW);
    end
    res = 1'b0;
    #1;
    checks++;
    if (ctrl !== C_INIT || stall_cnt !== 32'd0) begin
      failures++; $display("FAIL mid_reset got=%b stall=%0d exp=%b stall=0", ctrl, stall_cnt, C_INIT);
    end
    checks++;
    if (md_err_t !== 1'b0 || stall_cnt_t !== 32'd0) begin
      failures++; $display("FAIL mid_reset_err got err=%b stall=%0d exp 0/0", md_err_t, stall_cnt_t);
    end
    $display("mid_reset: ctrl=%b md_err=%b", ctrl, md_err_t);
    @(posedge clock);
    #1;
    res = 1'b1;
    dx_instr = 32'd0;
    md_rdy = 1'b1;
    @(negedge clock);
    checks++;
    if (ctrl !== C_INIT) begin
      failures++; $display("FAIL late_rdy_init got=%b exp=%b", ctrl, C_INIT);
    end
    next_cycle();
    next_cycle();
    @(negedge clock);
    checks++;
    if (ctrl !== C_RUN || stall_cnt !== 32'd0) begin
      failures++; $display("FAIL late_rdy_run got=%b stall=%0d exp=%b stall=0", ctrl, stall_cnt, C_RUN);
    end
    $display("mid_reset: after init ctrl=%b stall_cnt=%0d", ctrl, stall_cnt);
    md_rdy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_flush();
    test_multdiv();
    test_timeout();
    test_reset_mid_md();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
